// File: rtl/gpio_axi_arbiter.sv
// Two-master AXI-lite arbiter in front of the single GPIO slave, one complete transaction at a time.
// Latency: one IDLE cycle to arbitrate, then each phase is forwarded combinationally (zero added delay).
// Backpressure: slave ready/valid reach the owner only; a non-owner's valid is never acked and simply waits.
module gpio_axi_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] m_awaddr,
   input  logic [1:0]  m_awvalid,
   output logic [1:0]  m_awready,
   input  logic [63:0] m_wdata,
   input  logic [1:0]  m_wvalid,
   output logic [1:0]  m_wready,
   output logic [1:0]  m_bvalid,
   input  logic [1:0]  m_bready,
   input  logic [63:0] m_araddr,
   input  logic [1:0]  m_arvalid,
   output logic [1:0]  m_arready,
   output logic [63:0] m_rdata,
   output logic [1:0]  m_rvalid,
   input  logic [1:0]  m_rready,
   output logic [31:0] s_awaddr,
   output logic        s_awvalid,
   input  logic        s_awready,
   output logic [31:0] s_wdata,
   output logic        s_wvalid,
   input  logic        s_wready,
   input  logic        s_bvalid,
   output logic        s_bready,
   output logic [31:0] s_araddr,
   output logic        s_arvalid,
   input  logic        s_arready,
   input  logic [31:0] s_rdata,
   input  logic        s_rvalid,
   output logic        s_rready,
   output logic [1:0]  grant
);

   typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

   state_t     state, state_nxt;
   logic       owner, owner_nxt;
   logic       op, op_nxt;        // 1 = write, 0 = read
   logic       rr_ptr, rr_ptr_nxt;
   logic [1:0] req;
   logic       win;
   logic       done;

   assign req = m_awvalid | m_arvalid;

   // Winner among requesters: rr_ptr is the first candidate under round-robin, master 0 otherwise
   always_comb begin
      win = 1'b0;
      if (RR_EN) win = req[rr_ptr] ? rr_ptr : ~rr_ptr;
      else       win = req[0] ? 1'b0 : 1'b1;
   end

   // State, owner and round-robin pointer; reset abandons any in-flight transaction
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         owner  <= 1'b0;
         op     <= 1'b0;
         rr_ptr <= 1'b0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         op     <= op_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   // Next state plus phase mirroring between the owner and the slave; everything else stays 0
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      op_nxt     = op;
      rr_ptr_nxt = rr_ptr;
      done       = 1'b0;
      m_awready  = 2'b00;
      m_wready   = 2'b00;
      m_bvalid   = 2'b00;
      m_arready  = 2'b00;
      m_rvalid   = 2'b00;
      s_awvalid  = 1'b0;
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               owner_nxt = win;
               // a master offering both AW and AR is served as a write first
               op_nxt    = m_awvalid[win];
               state_nxt = m_awvalid[win] ? WADDR : RADDR;
            end
         end
         WADDR: begin
            s_awvalid        = m_awvalid[owner];
            m_awready[owner] = s_awready;
            if (m_awvalid[owner] && s_awready) state_nxt = WDATA;
         end
         WDATA: begin
            s_wvalid        = m_wvalid[owner];
            m_wready[owner] = s_wready;
            if (m_wvalid[owner] && s_wready) state_nxt = WRESP;
         end
         WRESP: begin
            m_bvalid[owner] = s_bvalid;
            s_bready        = m_bready[owner];
            done            = op & s_bvalid & m_bready[owner];
         end
         RADDR: begin
            s_arvalid        = m_arvalid[owner];
            m_arready[owner] = s_arready;
            if (m_arvalid[owner] && s_arready) state_nxt = RDATA;
         end
         RDATA: begin
            m_rvalid[owner] = s_rvalid;
            s_rready        = m_rready[owner];
            done            = ~op & s_rvalid & m_rready[owner];
         end
         default: state_nxt = IDLE;
      endcase
      if (done) begin
         state_nxt = IDLE;
         if (RR_EN) rr_ptr_nxt = ~owner;
      end
   end

   // Address/data paths select the owner's slice; forced to 0 while idle
   always_comb begin
      s_awaddr = 32'h0;
      s_wdata  = 32'h0;
      s_araddr = 32'h0;
      if (state != IDLE) begin
         s_awaddr = owner ? m_awaddr[63:32] : m_awaddr[31:0];
         s_wdata  = owner ? m_wdata[63:32]  : m_wdata[31:0];
         s_araddr = owner ? m_araddr[63:32] : m_araddr[31:0];
      end
   end

   assign m_rdata = {s_rdata, s_rdata};
   assign grant   = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_gpio_axi_arbiter.sv
// Bench for gpio_axi_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: the model expects one IDLE arbitration cycle and combinational forwarding in every phase.
// Backpressure: the GPIO slave and the masters insert random ready/valid stalls.
module tb_gpio_axi_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, grant;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;

   gpio_axi_arbiter #(.RR_EN(1'b1)) dut (
      .clock(clock), .reset(reset),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .grant(grant)
   );

   // Fixed-priority instance: both masters read forever, slave always ready/valid
   logic [63:0] fp_m_rdata;
   logic [1:0]  fp_awready, fp_wready, fp_bvalid, fp_arready, fp_rvalid, fp_grant;
   logic [31:0] fp_s_awaddr, fp_s_wdata, fp_s_araddr;
   logic        fp_s_awvalid, fp_s_wvalid, fp_s_bready, fp_s_arvalid, fp_s_rready;

   gpio_axi_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clock(clock), .reset(reset),
      .m_awaddr(64'h0), .m_awvalid(2'b00), .m_awready(fp_awready),
      .m_wdata(64'h0), .m_wvalid(2'b00), .m_wready(fp_wready),
      .m_bvalid(fp_bvalid), .m_bready(2'b00),
      .m_araddr(64'h0), .m_arvalid(2'b11), .m_arready(fp_arready),
      .m_rdata(fp_m_rdata), .m_rvalid(fp_rvalid), .m_rready(2'b11),
      .s_awaddr(fp_s_awaddr), .s_awvalid(fp_s_awvalid), .s_awready(1'b0),
      .s_wdata(fp_s_wdata), .s_wvalid(fp_s_wvalid), .s_wready(1'b0),
      .s_bvalid(1'b0), .s_bready(fp_s_bready),
      .s_araddr(fp_s_araddr), .s_arvalid(fp_s_arvalid), .s_arready(1'b1),
      .s_rdata(32'h0), .s_rvalid(1'b1), .s_rready(fp_s_rready),
      .grant(fp_grant)
   );

   int checks, errors;

   // master drivers
   logic [1:0]  wr_busy, rd_busy, aw_done, w_done, ar_done;
   int          b_hold [2];
   logic [31:0] wr_addr [2], wr_data [2], rd_addr [2];
   int          wr_cnt [2], rd_cnt [2], st_cnt;
   logic [1:0]  hs_aw, hs_w, hs_b, hs_ar, hs_r;
   // GPIO slave model
   logic        shs_w, shs_b, shs_ar, shs_r, b_pend, r_pend;
   int          b_dly, r_dly;
   logic [7:0]  pins, pend_pins;
   logic [31:0] r_dat;
   logic        rand_mode, w_block, chk_en, rst_seen;
   // transaction-level reference: who owns the slave, how many handshakes of the transaction are done
   bit          act, wr_op;
   int          own, last, n_hs, fp_p;
   logic [7:0]  mpins;
   int          win_q [$];
   int          op_q [$];
   logic [31:0] seen_awaddr, seen_wdata, last_rd0;
   int          bhold_cyc, leak_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic rdy();
      if (rand_mode) return ($urandom_range(0, 3) != 0);
      return 1'b1;
   endfunction

   function automatic int win_at(input int k);
      if (k < win_q.size()) return win_q[k];
      return -1;
   endfunction

   function automatic int op_at(input int k);
      if (k < op_q.size()) return op_q[k];
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < 2; i++) begin
         m_awvalid[i] = wr_busy[i] & ~aw_done[i];
         m_wvalid[i]  = wr_busy[i] & ~w_done[i];
         m_bready[i]  = wr_busy[i] & aw_done[i] & w_done[i] & (b_hold[i] == 0) & rdy();
         m_arvalid[i] = rd_busy[i] & ~ar_done[i];
         m_rready[i]  = rd_busy[i] & ar_done[i] & rdy();
         m_awaddr[i*32 +: 32] = wr_addr[i];
         m_wdata[i*32 +: 32]  = wr_data[i];
         m_araddr[i*32 +: 32] = rd_addr[i];
      end
      s_awready = rdy();
      s_wready  = rdy() & ~w_block;
      s_arready = rdy();
      s_bvalid  = b_pend & (b_dly == 0);
      s_rvalid  = r_pend & (r_dly == 0);
      s_rdata   = r_dat;
   endtask

   task automatic start_write(input int i, input logic [31:0] a, input logic [31:0] d, input int hold);
      if (!wr_busy[i]) begin
         wr_busy[i] = 1'b1; aw_done[i] = 1'b0; w_done[i] = 1'b0;
         wr_addr[i] = a; wr_data[i] = d; b_hold[i] = hold; st_cnt++;
         drive_inputs();
      end
   endtask

   task automatic start_read(input int i, input logic [31:0] a);
      if (!rd_busy[i]) begin
         rd_busy[i] = 1'b1; ar_done[i] = 1'b0; rd_addr[i] = a; st_cnt++;
         drive_inputs();
      end
   endtask

   // Sample away from the edge: compare DUT against the model, then advance the model
   task automatic monitor();
      logic [1:0] eg, e_awr, e_wr, e_bv, e_arr, e_rv, req;
      logic       e_awv, e_wv, e_bre, e_arv, e_rre, hs;
      int         ch, w;
      eg = '0; e_awr = '0; e_wr = '0; e_bv = '0; e_arr = '0; e_rv = '0;
      e_awv = 0; e_wv = 0; e_bre = 0; e_arv = 0; e_rre = 0; hs = 0;
      ch = wr_op ? n_hs : 3 + n_hs;   // 0 AW, 1 W, 2 B, 3 AR, 4 R
      hs_aw = m_awvalid & m_awready; hs_w = m_wvalid & m_wready; hs_b = m_bvalid & m_bready;
      hs_ar = m_arvalid & m_arready; hs_r = m_rvalid & m_rready;
      shs_w = s_wvalid & s_wready; shs_b = s_bvalid & s_bready;
      shs_ar = s_arvalid & s_arready; shs_r = s_rvalid & s_rready;
      if (shs_w) begin pend_pins = s_wdata[7:0]; seen_wdata = s_wdata; end
      if (s_awvalid && s_awready) seen_awaddr = s_awaddr;
      if (act) begin
         eg = 2'b01 << own;
         case (ch)
            0: begin e_awv = m_awvalid[own]; e_awr[own] = s_awready; hs = m_awvalid[own] & s_awready; end
            1: begin e_wv = m_wvalid[own]; e_wr[own] = s_wready; hs = m_wvalid[own] & s_wready; end
            2: begin e_bv[own] = s_bvalid; e_bre = m_bready[own]; hs = s_bvalid & m_bready[own]; end
            3: begin e_arv = m_arvalid[own]; e_arr[own] = s_arready; hs = m_arvalid[own] & s_arready; end
            4: begin e_rv[own] = s_rvalid; e_rre = m_rready[own]; hs = s_rvalid & m_rready[own]; end
            default: ;
         endcase
      end
      if (chk_en) begin
         check("grant", grant, eg);
         check("slave_ctl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, {e_awv, e_wv, e_bre, e_arv, e_rre});
         check("master_ctl", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, {e_awr, e_wr, e_bv, e_arr, e_rv});
         check("rdata_fanout", m_rdata, {s_rdata, s_rdata});
         if (act && ch == 0 && s_awvalid) check("s_awaddr", s_awaddr, m_awaddr[own*32 +: 32]);
         if (act && ch == 1 && s_wvalid) check("s_wdata", s_wdata, m_wdata[own*32 +: 32]);
         if (act && ch == 3 && s_arvalid) check("s_araddr", s_araddr, m_araddr[own*32 +: 32]);
         if (act && ch == 4 && hs) check("rdata_pins", m_rdata[own*32 +: 32], {24'h0, mpins});
         if (grant == 2'b10 && s_bvalid && !s_bready) bhold_cyc++;
         if (grant == 2'b10 && m_awready[0]) leak_cyc++;
         check("fp_ctl", {fp_grant, fp_arready, fp_rvalid, fp_s_arvalid, fp_s_rready,
                          fp_awready, fp_wready, fp_bvalid, fp_s_awvalid, fp_s_wvalid, fp_s_bready},
                         {(fp_p != 0) ? 2'b01 : 2'b00, (fp_p == 1) ? 2'b01 : 2'b00, (fp_p == 2) ? 2'b01 : 2'b00,
                          fp_p == 1, fp_p == 2, 9'h0});
         check("fp_data", |{fp_s_awaddr, fp_s_wdata, fp_s_araddr, fp_m_rdata}, 0);
      end
      fp_p = reset ? (fp_p + 1) % 3 : 0;
      if (!reset) begin
         act = 0; last = 1; rst_seen = 1;
      end else if (act) begin
         if (hs) begin
            if (ch == 1) mpins = m_wdata[own*32 +: 8];
            if (ch == 4 && own == 0) last_rd0 = m_rdata[31:0];
            n_hs++;
            if (ch == 2 || ch == 4) begin act = 0; last = own; end
         end
      end else begin
         req = m_awvalid | m_arvalid;
         if (req != 2'b00) begin
            // the master not served most recently goes first when both ask
            w = (req == 2'b11) ? 1 - last : (req[0] ? 0 : 1);
            act = 1; own = w; wr_op = m_awvalid[w]; n_hs = 0;
            win_q.push_back(w); op_q.push_back(int'(wr_op));
         end
      end
   endtask

   // After the edge: retire handshakes in the masters and the GPIO slave, then drive new inputs
   task automatic advance();
      if (rst_seen) begin
         rst_seen = 0; wr_busy = '0; rd_busy = '0; aw_done = '0; w_done = '0; ar_done = '0;
         b_pend = 0; r_pend = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (b_hold[i] > 0 && wr_busy[i] && aw_done[i] && w_done[i]) b_hold[i]--;
            if (hs_aw[i]) aw_done[i] = 1'b1;
            if (hs_w[i])  w_done[i] = 1'b1;
            if (hs_b[i])  begin wr_busy[i] = 1'b0; wr_cnt[i]++; end
            if (hs_ar[i]) ar_done[i] = 1'b1;
            if (hs_r[i])  begin rd_busy[i] = 1'b0; rd_cnt[i]++; end
         end
         if (b_pend && b_dly > 0) b_dly--;
         if (r_pend && r_dly > 0) r_dly--;
         if (shs_b) b_pend = 0;
         if (shs_r) r_pend = 0;
         if (shs_w) begin pins = pend_pins; b_pend = 1; b_dly = rand_mode ? $urandom_range(0, 3) : 0; end
         if (shs_ar) begin r_pend = 1; r_dat = {24'h0, pins}; r_dly = rand_mode ? $urandom_range(0, 3) : 0; end
      end
      drive_inputs();
   endtask

   task automatic cycle();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      advance();
   endtask

   task automatic wait_idle(input int max_cyc);
      int k;
      k = 0;
      while ((wr_busy != 2'b00 || rd_busy != 2'b00) && k < max_cyc) begin
         cycle();
         k++;
      end
      check("idle_timeout", {wr_busy, rd_busy}, 4'h0);
   endtask

   initial begin
      int base, k, done0, st0;
      checks = 0; errors = 0; st_cnt = 0;
      wr_busy = '0; rd_busy = '0; aw_done = '0; w_done = '0; ar_done = '0;
      for (int i = 0; i < 2; i++) begin
         b_hold[i] = 0; wr_addr[i] = '0; wr_data[i] = '0; rd_addr[i] = '0; wr_cnt[i] = 0; rd_cnt[i] = 0;
      end
      hs_aw = '0; hs_w = '0; hs_b = '0; hs_ar = '0; hs_r = '0;
      shs_w = 0; shs_b = 0; shs_ar = 0; shs_r = 0; b_pend = 0; r_pend = 0; b_dly = 0; r_dly = 0;
      pins = '0; pend_pins = '0; mpins = '0; r_dat = '0;
      rand_mode = 0; w_block = 0; chk_en = 0; rst_seen = 0;
      act = 0; wr_op = 0; own = 0; last = 1; n_hs = 0; fp_p = 0;
      seen_awaddr = '0; seen_wdata = '0; last_rd0 = '0; bhold_cyc = 0; leak_cyc = 0;
      reset = 1'b0;
      drive_inputs();
      repeat (2) cycle();
      chk_en = 1; reset = 1'b1;
      cycle();
      check("rst_grant", grant, 2'b00);
      check("rst_slave_ctl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 5'h0);
      check("rst_master_ctl", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 10'h0);

      // single write from master 0
      start_write(0, 32'h3, 32'h5, 0);
      wait_idle(50);
      check("w0_awaddr", seen_awaddr, 32'h3);
      check("w0_wdata", seen_wdata, 32'h5);
      check("w0_winner", win_at(0), 0);
      check("w0_bcount", wr_cnt[0], 1);
      check("w0_grant_idle", grant, 2'b00);
      check("w0_pins", pins, 8'h05);

      // simultaneous reads from reset state
      reset = 1'b0; cycle(); reset = 1'b1;
      base = win_q.size();
      start_read(0, 32'h3); start_read(1, 32'h3);
      wait_idle(50);
      check("rr_first", win_at(base), 0);
      check("rr_second", win_at(base + 1), 1);
      start_write(0, 32'h1, 32'h11, 0); start_write(1, 32'h2, 32'h22, 0);
      wait_idle(50);
      check("rr_ptr_back_to_0", win_at(base + 2), 0);
      check("rr_then_1", win_at(base + 3), 1);

      // master 1 stalls the B channel while master 0 waits with AW
      base = win_q.size(); bhold_cyc = 0; leak_cyc = 0;
      start_write(1, 32'h1, 32'h3C, 5);
      cycle();
      start_write(0, 32'h2, 32'h81, 0);
      wait_idle(100);
      check("bhold_cycles", bhold_cyc, 5);
      check("aw_leak", leak_cyc, 0);
      check("bhold_order0", win_at(base), 1);
      check("bhold_order1", win_at(base + 1), 0);
      check("bhold_pins", pins, 8'h81);

      // AW and AR together from master 0: write then read back
      base = op_q.size();
      start_write(0, 32'h3, 32'hA7, 0); start_read(0, 32'h3);
      wait_idle(50);
      check("awar_op0_write", op_at(base), 1);
      check("awar_op1_read", op_at(base + 1), 0);
      check("awar_rdata", last_rd0, 32'hA7);

      // reset while stuck in the W phase
      w_block = 1;
      start_write(1, 32'h4, 32'h99, 0);
      k = 0;
      while (!(act && wr_op && n_hs == 1) && k < 20) begin cycle(); k++; end
      check("reach_wdata", act && wr_op && n_hs == 1, 1);
      reset = 1'b0;
      cycle();
      check("midrst_grant", grant, 2'b00);
      check("midrst_slave_ctl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 5'h0);
      check("midrst_master_ctl", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 10'h0);
      reset = 1'b1; w_block = 0;
      done0 = wr_cnt[1];
      start_write(1, 32'h4, 32'h5A, 0);
      wait_idle(50);
      check("midrst_new_write", wr_cnt[1] - done0, 1);
      check("midrst_pins", pins, 8'h5A);

      // randomized traffic
      rand_mode = 1;
      st0 = st_cnt; done0 = wr_cnt[0] + wr_cnt[1] + rd_cnt[0] + rd_cnt[1];
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 1) start_write(i, $urandom, $urandom, $urandom_range(0, 2));
               else start_read(i, $urandom);
            end
         end
         cycle();
      end
      wait_idle(400);
      check("rand_all_done", wr_cnt[0] + wr_cnt[1] + rd_cnt[0] + rd_cnt[1] - done0, st_cnt - st0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
